// File: rtl/pattern_video.sv
// pattern_video: test-pattern generator for a raster video pipeline.
// Frame ticks come from the rising edge of v_blank. An animation counter
// advances every FRAME_DIV ticks. After enable, BLANK_FRAMES black frames
// are forced before the selected pattern is shown.
// Ports:
//   clk, reset_n           clock, async active-low reset
//   en                     display enable
//   mode[2:0]              pattern select (latched on frame tick)
//   x_pos, y_pos           current pixel column / row
//   valid_region           active-video pixel qualifier
//   v_blank                vertical blanking flag
//   value_red/green/blue   registered colour outputs (1 cycle latency)
//   anim                   animation counter
//   active                 high while the pattern is being displayed
module pattern_video #(
    parameter int unsigned X_W          = 10,
    parameter int unsigned Y_W          = 10,
    parameter int unsigned C_W          = 8,
    parameter int unsigned FRAME_DIV    = 1,
    parameter int unsigned BLANK_FRAMES = 10
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic [2:0]     mode,
    input  logic [X_W-1:0] x_pos,
    input  logic [Y_W-1:0] y_pos,
    input  logic           valid_region,
    input  logic           v_blank,
    output logic [C_W-1:0] value_red,
    output logic [C_W-1:0] value_green,
    output logic [C_W-1:0] value_blue,
    output logic [C_W-1:0] anim,
    output logic           active
);

    localparam logic [1:0] ST_OFF    = 2'd0;
    localparam logic [1:0] ST_WARMUP = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    // Extended coordinate widths so every fixed bit select stays in range.
    localparam int unsigned XE_W = (X_W > 5) ? X_W : 5;
    localparam int unsigned YT_W = (Y_W > C_W + 1) ? Y_W : C_W + 1;
    localparam int unsigned YE_W = (YT_W > 5) ? YT_W : 5;

    localparam logic [7:0] DIV_LAST   = 8'(FRAME_DIV - 1);
    localparam logic [7:0] BLANK_INIT = 8'(BLANK_FRAMES);

    logic             r_vblank_q;
    logic [7:0]       r_div;
    logic [C_W-1:0]   r_anim;
    logic [2:0]       r_mode_q;
    logic [1:0]       r_state;
    logic [7:0]       r_blank_cnt;
    logic             r_active;
    logic [C_W-1:0]   r_red;
    logic [C_W-1:0]   r_green;
    logic [C_W-1:0]   r_blue;

    logic             w_frame_tick;
    logic [1:0]       w_state_next;
    logic [7:0]       w_blank_next;
    logic [XE_W-1:0]  w_x_ext;
    logic [YE_W-1:0]  w_y_ext;
    logic [C_W-1:0]   w_red;
    logic [C_W-1:0]   w_green;
    logic [C_W-1:0]   w_blue;
    logic             w_unused;

    assign w_frame_tick = v_blank & ~r_vblank_q;
    assign w_x_ext      = XE_W'(x_pos);
    assign w_y_ext      = YE_W'(y_pos);
    // Coordinate bits that no pattern looks at.
    assign w_unused     = &{1'b0, w_x_ext, w_y_ext};

    // Frame edge detect, frame divider, animation counter and mode latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vblank_q <= 1'b0;
            r_div      <= '0;
            r_anim     <= '0;
            r_mode_q   <= '0;
        end else begin
            r_vblank_q <= v_blank;
            if (w_frame_tick) begin
                r_mode_q <= mode;
                if (r_div == DIV_LAST) begin
                    r_div  <= '0;
                    r_anim <= r_anim + C_W'(1);
                end else begin
                    r_div <= r_div + 8'd1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_OFF;
            r_blank_cnt <= '0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_blank_cnt <= w_blank_next;
            r_active    <= (w_state_next == ST_ACTIVE);
        end
    end

    // Next-state logic; a low enable overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        w_blank_next = r_blank_cnt;
        case (r_state)
            ST_OFF: begin
                if (en) begin
                    if (BLANK_FRAMES == 0) begin
                        w_state_next = ST_ACTIVE;
                    end else begin
                        w_state_next = ST_WARMUP;
                        w_blank_next = BLANK_INIT;
                    end
                end
            end
            ST_WARMUP: begin
                if (w_frame_tick) begin
                    if (r_blank_cnt == 8'd1) begin
                        w_state_next = ST_ACTIVE;
                        w_blank_next = '0;
                    end else begin
                        w_blank_next = r_blank_cnt - 8'd1;
                    end
                end
            end
            ST_ACTIVE: begin
                w_state_next = ST_ACTIVE;
            end
            default: begin
                w_state_next = ST_OFF;
            end
        endcase
        if (!en) begin
            w_state_next = ST_OFF;
        end
    end

    // Pattern generation from the latched mode and current animation step.
    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        case (r_mode_q)
            3'd1: begin
                w_red   = {C_W{w_x_ext[X_W-1]}};
                w_green = {C_W{w_x_ext[X_W-2]}};
                w_blue  = {C_W{w_x_ext[X_W-3]}};
            end
            3'd2: begin
                w_red   = {C_W{w_x_ext[4] ^ w_y_ext[4] ^ r_anim[0]}};
                w_green = w_red;
                w_blue  = w_red;
            end
            3'd3: begin
                w_red   = r_anim;
                w_green = r_anim;
                w_blue  = r_anim;
            end
            3'd4: begin
                w_red   = w_x_ext[C_W-1:0] + r_anim;
                w_green = w_y_ext[C_W-1:0] + r_anim;
            end
            default: begin
                w_red   = w_x_ext[C_W-1:0];
                w_green = w_y_ext[C_W:1];
                w_blue  = r_anim;
            end
        endcase
    end

    // Colour output registers; black unless displaying a valid pixel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if ((r_state == ST_ACTIVE) && valid_region) begin
            r_red   <= w_red;
            r_green <= w_green;
            r_blue  <= w_blue;
        end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end
    end

    assign value_red   = r_red;
    assign value_green = r_green;
    assign value_blue  = r_blue;
    assign anim        = r_anim;
    assign active      = r_active;

endmodule

// File: doc/pattern_video.md
PATTERN_VIDEO -- requirements
Module: pattern_video

Interface
REQ-001 SHALL have parameter X_W, default 10, width of x_pos.
REQ-002 SHALL have parameter Y_W, default 10, width of y_pos.
REQ-003 SHALL have parameter C_W, default 8, width of each colour output; legal range 1..X_W-1.
REQ-004 SHALL have parameter FRAME_DIV, default 1, frames per animation step; legal range 1..255.
REQ-005 SHALL have parameter BLANK_FRAMES, default 10, black frames forced after enable rises; legal range 0..255.
REQ-006 SHALL have ports:
 clk  input  1  single clock; all logic on rising edge
 reset_n  input  1  asynchronous, active-low reset
 en  input  1  display enable
 mode  input  3  pattern select
 x_pos  input  X_W  pixel column
 y_pos  input  Y_W  pixel row
 valid_region  input  1  active-video pixel qualifier
 v_blank  input  1  vertical blanking flag
 value_red  output  C_W  red
 value_green  output  C_W  green
 value_blue  output  C_W  blue
 anim  output  C_W  animation counter
 active  output  1  high in ACTIVE state

Function
REQ-007 SHALL generate frame_tick for one cycle when v_blank is 1 and the previous-cycle v_blank was 0.
REQ-008 SHALL count frame_tick in an 8-bit divider; when divider = FRAME_DIV-1 on a tick, divider clears and anim increments by 1, wrapping 2^C_W-1 -> 0.
REQ-009 SHALL latch mode into mode_q only on frame_tick; a mode change mid-frame takes effect from the next frame.
REQ-010 SHALL run a three-state FSM: OFF, WARMUP, ACTIVE.
REQ-011 OFF: en=1 -> WARMUP with blank counter loaded to BLANK_FRAMES; if BLANK_FRAMES=0 -> ACTIVE directly.
REQ-012 WARMUP: blank counter decrements on each frame_tick; a tick at count 1 -> ACTIVE.
REQ-013 Any state: en=0 -> OFF on the next edge, overriding all other transitions.
REQ-014 Colour outputs SHALL be all-zero unless state=ACTIVE and valid_region=1.
REQ-015 In ACTIVE with valid_region=1, SHALL produce, by mode_q:
 0 gradient: R=x_pos[C_W-1:0], G=y_pos[C_W:1], B=anim
 1 colour bars: b=x_pos[X_W-1:X_W-3]; R/G/B all-ones if b[2]/b[1]/b[0] set, else zero
 2 checker: x_pos[4]^y_pos[4]^anim[0]=1 -> all-ones on all channels, else zero
 3 solid: R=G=B=anim
 4 scroll: R=(x_pos+anim) mod 2^C_W, G=(y_pos+anim) mod 2^C_W, B=0
 5-7: identical to mode 0
REQ-016 Additions SHALL be zero-extended to the wider operand and truncated to the low C_W bits; y_pos[C_W:1] is zero-extended when Y_W <= C_W.
REQ-017 Colour outputs SHALL be registered with exactly one clock latency from x_pos/y_pos/valid_region.
REQ-018 A frame_tick coinciding with the ACTIVE transition SHALL update anim and mode_q in the same edge; the first ACTIVE pixel uses updated values.
REQ-019 anim and the divider SHALL run in every FSM state, including OFF.

Reset
REQ-020 reset_n=0 SHALL asynchronously clear colour outputs, anim, divider, blank counter, edge-detect register, and mode_q to 0, set state OFF, and drive active=0.
REQ-021 Release of reset_n SHALL take effect at the next rising clk; previous-cycle v_blank is 0 after reset, so v_blank=1 on the first clock after reset produces a frame_tick.
REQ-022 Reset mid-WARMUP SHALL return to OFF; the warm-up restarts in full on the next en.

Verification
REQ-023 Reset with en=1, BLANK_FRAMES=10, mode=0 -> outputs zero through 10 frame_ticks, active=1 after the 10th, then a pixel (x=0x3A5, y=0x0C4) -> R=0xA5, G=0x62, B=anim one cycle later.
REQ-024 FRAME_DIV=3, 7 frame_ticks -> anim=2; with C_W=8 and anim=255, the next step -> anim=0.
REQ-025 mode changed 0->1 mid-frame -> pattern unchanged until next frame_tick; then x_pos=0x2C0 (b=5) -> R=0xFF, G=0x00, B=0xFF.
REQ-026 en dropped for one cycle in ACTIVE -> black from next cycle; 10 frames of warm-up repeat.
REQ-027 valid_region=0 in ACTIVE, any mode -> all colours 0; mode 4, anim=0xF0, x_pos=0x020 -> R=0x10.
REQ-028 reset_n asserted mid-frame asynchronously -> outputs 0 before the next clk edge; state=OFF, anim=0.
